// File: rtl/denoise2d_sched_pkg.sv
// Shared types and defaults for the denoise2d op scheduler.
package denoise2d_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam int IDX_W_DEF  = 16;
  localparam int TIME_W_DEF = 24;

  function automatic longint unsigned calc_iters(input int rows, input int cols);
    return longint'(rows) * longint'(cols);
  endfunction

endpackage

// File: rtl/op_iter_counter.sv
// Per-op (x,y) walker over the ROWS x COLS domain; x/y show the current issue,
// or the last issued index while idle, and freeze once the final point is issued.
module op_iter_counter #(
  parameter int ROWS  = 64,
  parameter int COLS  = 64,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             fin
);

  logic [IDX_W-1:0] nx_q, ny_q, lx_q, ly_q;
  logic             fin_q;
  logic             last_col, last_row;

  assign last_col = (nx_q == IDX_W'(COLS - 1));
  assign last_row = (ny_q == IDX_W'(ROWS - 1));

  // nx/ny point at the next point to issue; lx/ly remember the one last issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nx_q  <= '0;
      ny_q  <= '0;
      lx_q  <= '0;
      ly_q  <= '0;
      fin_q <= 1'b0;
    end else if (clr) begin
      nx_q  <= '0;
      ny_q  <= '0;
      lx_q  <= '0;
      ly_q  <= '0;
      fin_q <= 1'b0;
    end else if (en) begin
      lx_q <= nx_q;
      ly_q <= ny_q;
      if (last_col) begin
        if (last_row) begin
          fin_q <= 1'b1;
        end else begin
          nx_q <= '0;
          ny_q <= ny_q + IDX_W'(1);
        end
      end else begin
        nx_q <= nx_q + IDX_W'(1);
      end
    end
  end

  assign x   = en ? nx_q : lx_q;
  assign y   = en ? ny_q : ly_q;
  assign fin = fin_q;

endmodule

// File: rtl/denoise2d_op_scheduler.sv
// Frame sequencer for the denoise2d stencil pipeline: one global time base,
// per-op start offsets, per-op iteration counters and the start/done handshake.
module denoise2d_op_scheduler
  import denoise2d_sched_pkg::*;
#(
  parameter int NUM_OPS = 8,
  parameter int ROWS    = 64,
  parameter int COLS    = 64,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TIME_W  = TIME_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  input  logic [NUM_OPS*TIME_W-1:0] op_offset,
  output logic [NUM_OPS-1:0]        op_en,
  output logic [NUM_OPS*IDX_W-1:0]  op_x,
  output logic [NUM_OPS*IDX_W-1:0]  op_y,
  output logic                      busy,
  output logic                      done
);

  localparam longint unsigned ITERS = calc_iters(ROWS, COLS);

  sched_state_e              state_q, state_d;
  logic [TIME_W-1:0]         t_q;
  logic [NUM_OPS*TIME_W-1:0] off_q;
  logic [NUM_OPS-1:0]        op_fin, op_last;
  logic                      start_acc, all_fin;

  assign start_acc = (state_q == IDLE) && start;
  // Looks one issue ahead so DONE lands the cycle right after the final issue
  assign all_fin   = &(op_fin | op_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = RUN;
      RUN:     if (all_fin) state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Global time base: counts unstalled RUN cycles, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q   <= '0;
      off_q <= '0;
    end else if (start_acc) begin
      t_q   <= '0;
      off_q <= op_offset;
    end else if ((state_q == RUN) && !stall && (t_q != '1)) begin
      t_q <= t_q + TIME_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    assign op_en[k] = (state_q == RUN) && !stall &&
                      (t_q >= off_q[k*TIME_W +: TIME_W]) && !op_fin[k];

    assign op_last[k] = op_en[k] &&
                        (op_x[k*IDX_W +: IDX_W] == IDX_W'(COLS - 1)) &&
                        (op_y[k*IDX_W +: IDX_W] == IDX_W'(ROWS - 1));

    op_iter_counter #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .IDX_W (IDX_W)
    ) u_iter (
      .clk (clk),
      .rst (rst),
      .clr (start_acc),
      .en  (op_en[k]),
      .x   (op_x[k*IDX_W +: IDX_W]),
      .y   (op_y[k*IDX_W +: IDX_W]),
      .fin (op_fin[k])
    );
  end

  // The latest-starting op must finish before t could saturate
  logic [TIME_W-1:0] max_off;
  logic [63:0]       need_t;

  always_comb begin
    max_off = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (op_offset[k*TIME_W +: TIME_W] > max_off) max_off = op_offset[k*TIME_W +: TIME_W];
    end
  end

  assign need_t = 64'(max_off) + 64'(ITERS);

  always_ff @(posedge clk) begin
    if (!rst && start_acc) begin
      assert (need_t < (64'(1) << TIME_W));
    end
  end

endmodule

// File: tb/tb_denoise2d_op_scheduler.sv
// Directed bench for denoise2d_op_scheduler with NUM_OPS=2, ROWS=2, COLS=3.
module tb_denoise2d_op_scheduler;

  localparam int NUM_OPS = 2;
  localparam int ROWS    = 2;
  localparam int COLS    = 3;
  localparam int IDX_W   = 16;
  localparam int TIME_W  = 24;
  localparam int ITERS   = ROWS * COLS;

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic                      stall;
  logic [NUM_OPS*TIME_W-1:0] op_offset;
  logic [NUM_OPS-1:0]        op_en;
  logic [NUM_OPS*IDX_W-1:0]  op_x;
  logic [NUM_OPS*IDX_W-1:0]  op_y;
  logic                      busy;
  logic                      done;

  int n_cmp = 0;
  int n_mis = 0;

  denoise2d_op_scheduler #(
    .NUM_OPS (NUM_OPS),
    .ROWS    (ROWS),
    .COLS    (COLS),
    .IDX_W   (IDX_W),
    .TIME_W  (TIME_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .op_offset (op_offset),
    .op_en     (op_en),
    .op_x      (op_x),
    .op_y      (op_y),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " en"},   64'(op_en), 64'(0));
    check({tag, " x"},    64'(op_x),  64'(0));
    check({tag, " y"},    64'(op_y),  64'(0));
    check({tag, " busy"}, 64'(busy),  64'(0));
    check({tag, " done"}, 64'(done),  64'(0));
  endtask

  // One frame: start in c=0, optional stall window [s_lo,s_hi], optional stall
  // with the start (s0), re-asserted start in cycles ra/rb, cycles 0..n_cyc.
  task automatic run_frame(input string name, input int off0, input int off1,
                           input int s_lo, input int s_hi, input bit s0,
                           input int ra, input int rb, input int n_cyc,
                           input int exp_done);
    int offs[2];
    int tot_st, d_cyc, first_done, n_pulse;
    offs[0] = off0;
    offs[1] = off1;
    tot_st = 0;
    for (int j = 1; j <= 1000; j++) if (j >= s_lo && j <= s_hi) tot_st++;
    d_cyc      = ((off0 > off1) ? off0 : off1) + ITERS + 1 + tot_st;
    first_done = -1;
    n_pulse    = 0;
    for (int c = 0; c <= n_cyc; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == ra) || (c == rb);
      stall = (c == 0) ? s0 : (c >= s_lo && c <= s_hi);
      // Later offset changes must not affect a frame already started
      op_offset = (c == 0) ? {TIME_W'(off1), TIME_W'(off0)} : {TIME_W'(7), TIME_W'(7)};
      @(negedge clk);
      if (done) begin
        n_pulse++;
        if (first_done < 0) first_done = c;
      end
      if (c == 0) begin
        check($sformatf("%s c0 en", name),   64'(op_en), 64'(0));
        check($sformatf("%s c0 busy", name), 64'(busy),  64'(0));
        check($sformatf("%s c0 done", name), 64'(done),  64'(0));
      end else begin
        int nst, t, m, idx;
        bit stl;
        logic [1:0]  e_en;
        logic [31:0] e_x, e_y;
        nst = 0;
        for (int j = 1; j < c; j++) if (j >= s_lo && j <= s_hi) nst++;
        t   = c - 1 - nst;
        stl = (c >= s_lo && c <= s_hi);
        for (int k = 0; k < 2; k++) begin
          e_en[k] = (c < d_cyc) && !stl && (t >= offs[k]) && (t < offs[k] + ITERS);
          if (e_en[k]) begin
            idx = t - offs[k];
          end else begin
            m = t - offs[k];
            if (m < 0) m = 0;
            if (m > ITERS) m = ITERS;
            idx = (m > 0) ? m - 1 : 0;
          end
          e_x[k*16 +: 16] = 16'(idx % COLS);
          e_y[k*16 +: 16] = 16'(idx / COLS);
        end
        check($sformatf("%s c%0d en", name, c),   64'(op_en), 64'(e_en));
        check($sformatf("%s c%0d x", name, c),    64'(op_x),  64'(e_x));
        check($sformatf("%s c%0d y", name, c),    64'(op_y),  64'(e_y));
        check($sformatf("%s c%0d busy", name, c), 64'(busy),  64'(c < d_cyc));
        check($sformatf("%s c%0d done", name, c), 64'(done),  64'(c == d_cyc));
      end
    end
    if (exp_done >= 0) begin
      check($sformatf("%s done_cycle", name),  64'(first_done), 64'(exp_done));
      check($sformatf("%s done_pulses", name), 64'(n_pulse),    64'(1));
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    op_offset = '0;
    #12;
    check_idle_zero("reset");
    rst = 1'b0;

    run_frame("s1", 0, 0, 100, 99, 1'b0, -1, -1, 7, 7);
    run_frame("s2", 0, 4, 100, 99, 1'b0, -1, -1, 11, 11);
    run_frame("s3", 0, 0, 3, 4, 1'b0, -1, -1, 9, 9);

    // Reset mid-cycle 3 of a frame, then idle cycles 4,5, then a fresh frame
    run_frame("s4a", 0, 0, 100, 99, 1'b0, -1, -1, 2, -1);
    @(posedge clk);
    #1;
    check("s4 pre_rst busy", 64'(busy), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("s4 rst");
    rst = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_idle_zero($sformatf("s4 c%0d", c));
    end
    run_frame("s4b", 0, 0, 100, 99, 1'b0, -1, -1, 7, 7);

    run_frame("s5a", 0, 0, 100, 99, 1'b0, 2, 7, 7, 7);
    run_frame("s5b", 0, 0, 100, 99, 1'b0, -1, -1, 7, 7);

    run_frame("s6", 5, 0, 100, 99, 1'b1, -1, -1, 12, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
